// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: pipeline controller for the PC/IF/ID/EX stages.
//   - Merges NUM_SRC stall requests into one per-stage hold mask through SRC_MASK.
//   - Redirects the PC from an EX jump or a CLINT trap. The trap wins when both fire.
//   - Keeps FLUSH_MASK applied for FLUSH_CYCLES cycles, counting the redirect cycle.
//   - Parks a redirect in PEND while the PC stage is stalled, then issues it.
//   - Counts stalled cycles and issued redirects in saturating counters.
// Ports:
//   clk, rst                          core clock; asynchronous active-low reset
//   ex_jump_flag/addr                 redirect request from EX
//   trap_jump_flag/addr               redirect request from CLINT
//   hold_req[NUM_SRC]                 per-source stall requests
//   perf_clr                          synchronous clear of both perf counters
//   hold_flag[STAGES]                 per-stage hold (bit0 PC, bit1 IF, bit2 ID, bit3 EX)
//   pc_jump_flag/addr                 PC redirect for this cycle
//   flush_busy                        controller is in PEND or FLUSH
//   perf_stall_cnt, perf_flush_cnt    perf counters

module pipe_ctrl_gen #(
   parameter int unsigned                  ADDR_W       = 32,
   parameter int unsigned                  NUM_SRC      = 3,
   parameter int unsigned                  STAGES       = 4,
   parameter logic [NUM_SRC*STAGES-1:0]    SRC_MASK     = 12'h761,
   parameter logic [STAGES-1:0]            FLUSH_MASK   = 4'b0110,
   parameter int unsigned                  FLUSH_CYCLES = 1,
   parameter int unsigned                  CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_jump_flag,
   input  logic [ADDR_W-1:0] ex_jump_addr,
   input  logic              trap_jump_flag,
   input  logic [ADDR_W-1:0] trap_jump_addr,
   input  logic [NUM_SRC-1:0] hold_req,
   input  logic              perf_clr,
   output logic [STAGES-1:0] hold_flag,
   output logic              pc_jump_flag,
   output logic [ADDR_W-1:0] pc_jump_addr,
   output logic              flush_busy,
   output logic [CNT_W-1:0]  perf_stall_cnt,
   output logic [CNT_W-1:0]  perf_flush_cnt
);

   // The counter has to hold FLUSH_CYCLES-1, and it needs at least one bit.
   localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StPend, StFlush} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic [STAGES-1:0] src_hold;
   logic              pc_busy;
   logic              issue;
   logic [ADDR_W-1:0] issue_addr;
   logic [STAGES-1:0] hold_int;

   assign req      = trap_jump_flag | ex_jump_flag;
   assign req_addr = trap_jump_flag ? trap_jump_addr : ex_jump_addr;

   always_comb begin
      src_hold = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hold_req[i]) begin
            src_hold = src_hold | SRC_MASK[i*STAGES +: STAGES];
         end
      end
   end

   assign pc_busy = src_hold[0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_addr_d = pend_addr_q;
      hold_int    = src_hold;
      issue       = 1'b0;
      issue_addr  = '0;

      unique case (state_q)
         StIdle, StFlush: begin
            if (state_q == StFlush) begin
               hold_int = src_hold | FLUSH_MASK;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = StIdle;
               end
            end
            // A new request restarts the sequence, whether or not a flush is running.
            if (req) begin
               hold_int = src_hold | FLUSH_MASK;
               if (pc_busy) begin
                  pend_addr_d = req_addr;
                  state_d     = StPend;
               end else begin
                  issue      = 1'b1;
                  issue_addr = req_addr;
               end
            end
         end
         StPend: begin
            hold_int = src_hold | FLUSH_MASK;
            if (req) begin
               pend_addr_d = req_addr;
            end
            if (!pc_busy) begin
               issue      = 1'b1;
               issue_addr = req ? req_addr : pend_addr_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue) begin
         if (FLUSH_CYCLES > 1) begin
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            state_d = StFlush;
         end else begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      end
   end

   // The outputs are combinational, so they are forced to zero while reset is held.
   always_comb begin
      hold_flag    = rst ? hold_int : '0;
      pc_jump_flag = rst & issue;
      pc_jump_addr = (rst && issue) ? issue_addr : '0;
      flush_busy   = rst & (state_q != StIdle);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if ((|hold_flag) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (pc_jump_flag && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pend_addr_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_addr_q <= pend_addr_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen. It runs two instances on the same inputs:
// dut uses the default parameters, and dut3 uses FLUSH_CYCLES=3.

module tb_pipe_ctrl_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_jump_flag;
   logic [31:0] ex_jump_addr;
   logic        trap_jump_flag;
   logic [31:0] trap_jump_addr;
   logic [2:0]  hold_req;
   logic        perf_clr;

   logic [3:0]  hold_flag, hold_flag3;
   logic        pc_jump_flag, pc_jump_flag3;
   logic [31:0] pc_jump_addr, pc_jump_addr3;
   logic        flush_busy, flush_busy3;
   logic [31:0] stall_cnt, stall_cnt3;
   logic [31:0] flush_cnt, flush_cnt3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_ctrl_gen dut (
      .clk            (clk),
      .rst            (rst),
      .ex_jump_flag   (ex_jump_flag),
      .ex_jump_addr   (ex_jump_addr),
      .trap_jump_flag (trap_jump_flag),
      .trap_jump_addr (trap_jump_addr),
      .hold_req       (hold_req),
      .perf_clr       (perf_clr),
      .hold_flag      (hold_flag),
      .pc_jump_flag   (pc_jump_flag),
      .pc_jump_addr   (pc_jump_addr),
      .flush_busy     (flush_busy),
      .perf_stall_cnt (stall_cnt),
      .perf_flush_cnt (flush_cnt)
   );

   pipe_ctrl_gen #(.FLUSH_CYCLES(3)) dut3 (
      .clk            (clk),
      .rst            (rst),
      .ex_jump_flag   (ex_jump_flag),
      .ex_jump_addr   (ex_jump_addr),
      .trap_jump_flag (trap_jump_flag),
      .trap_jump_addr (trap_jump_addr),
      .hold_req       (hold_req),
      .perf_clr       (perf_clr),
      .hold_flag      (hold_flag3),
      .pc_jump_flag   (pc_jump_flag3),
      .pc_jump_addr   (pc_jump_addr3),
      .flush_busy     (flush_busy3),
      .perf_stall_cnt (stall_cnt3),
      .perf_flush_cnt (flush_cnt3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ex_jump_flag = 1'b0; ex_jump_addr = '0; trap_jump_flag = 1'b0;
      trap_jump_addr = '0; hold_req = '0; perf_clr = 1'b0;

      // Reset: outputs stay at 0 even while a request is driven.
      #1 ex_jump_flag = 1'b1; ex_jump_addr = 32'h100; hold_req = 3'b001;
      #1;
      chk("rst_jump", pc_jump_flag, 0);
      chk("rst_addr", pc_jump_addr, 0);
      chk("rst_hold", hold_flag, 0);
      chk("rst_busy", flush_busy3, 0);
      chk("rst_cnt", stall_cnt, 0);
      ex_jump_flag = 1'b0; hold_req = '0;
      tick();
      rst = 1'b1;
      tick();

      // 1: ex jump 0x100 with no holds.
      ex_jump_flag = 1'b1; ex_jump_addr = 32'h100;
      #1;
      chk("t1_jump", pc_jump_flag, 1);
      chk("t1_addr", pc_jump_addr, 32'h100);
      chk("t1_hold", hold_flag, 4'b0110);
      tick();
      ex_jump_flag = 1'b0;
      #1;
      chk("t1_hold_next", hold_flag, 0);
      chk("t1_jump_next", pc_jump_flag, 0);
      chk("t1_flush_cnt", flush_cnt, 1);
      chk("t1_stall_cnt", stall_cnt, 1);
      tick(); tick(); tick();

      // 2: FLUSH_CYCLES=3 on dut3. Clear the counters first.
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      #1;
      chk("t2_clr", flush_cnt3, 0);
      ex_jump_flag = 1'b1; ex_jump_addr = 32'h200;
      #1;
      chk("t2_jump", pc_jump_flag3, 1);
      chk("t2_addr", pc_jump_addr3, 32'h200);
      chk("t2_hold0", hold_flag3, 4'b0110);
      chk("t2_busy0", flush_busy3, 0);
      tick();
      ex_jump_flag = 1'b0;
      #1;
      chk("t2_hold1", hold_flag3, 4'b0110);
      chk("t2_busy1", flush_busy3, 1);
      chk("t2_jump1", pc_jump_flag3, 0);
      tick();
      chk("t2_hold2", hold_flag3, 4'b0110);
      chk("t2_busy2", flush_busy3, 1);
      tick();
      chk("t2_hold3", hold_flag3, 0);
      chk("t2_busy3", flush_busy3, 0);
      chk("t2_flush_cnt", flush_cnt3, 1);
      chk("t2_stall_cnt", stall_cnt3, 3);

      // 3: PC held for 4 cycles, ex jump 0x300 on the second of them.
      hold_req = 3'b001;
      #1;
      chk("t3_hold_only", hold_flag, 4'b0001);
      chk("t3_jump0", pc_jump_flag, 0);
      tick();
      ex_jump_flag = 1'b1; ex_jump_addr = 32'h300;
      #1;
      chk("t3_jump1", pc_jump_flag, 0);
      chk("t3_hold1", hold_flag, 4'b0111);
      tick();
      ex_jump_flag = 1'b0;
      #1;
      chk("t3_jump2", pc_jump_flag, 0);
      chk("t3_busy2", flush_busy, 1);
      chk("t3_hold2", hold_flag, 4'b0111);
      tick();
      chk("t3_jump3", pc_jump_flag, 0);
      tick();
      hold_req = 3'b000;
      #1;
      chk("t3_jump4", pc_jump_flag, 1);
      chk("t3_addr4", pc_jump_addr, 32'h300);
      chk("t3_hold4", hold_flag, 4'b0110);
      tick();
      chk("t3_busy5", flush_busy, 0);
      chk("t3_jump5", pc_jump_flag, 0);
      chk("t3_addr5", pc_jump_addr, 0);

      // 4: trap wins over ex. A later trap then replaces the pending ex target.
      ex_jump_flag = 1'b1; ex_jump_addr = 32'h400;
      trap_jump_flag = 1'b1; trap_jump_addr = 32'h800;
      #1;
      chk("t4_jump", pc_jump_flag, 1);
      chk("t4_addr", pc_jump_addr, 32'h800);
      tick();
      trap_jump_flag = 1'b0; hold_req = 3'b001;
      #1;
      chk("t4_pend_jump", pc_jump_flag, 0);
      tick();
      ex_jump_flag = 1'b0; trap_jump_flag = 1'b1; trap_jump_addr = 32'h900;
      #1;
      chk("t4_pend_busy", flush_busy, 1);
      chk("t4_pend_jump2", pc_jump_flag, 0);
      tick();
      trap_jump_flag = 1'b0; hold_req = 3'b000;
      #1;
      chk("t4_rel_jump", pc_jump_flag, 1);
      chk("t4_rel_addr", pc_jump_addr, 32'h900);
      tick(); tick(); tick();

      // 5: stall mask and the stall counter, with perf_clr winning over a stall.
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      hold_req = 3'b101;
      #1;
      chk("t5_hold", hold_flag, 4'b0111);
      chk("t5_cnt0", stall_cnt, 0);
      tick();
      chk("t5_cnt1", stall_cnt, 1);
      tick();
      chk("t5_cnt2", stall_cnt, 2);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      #1;
      chk("t5_clr", stall_cnt, 0);
      tick();
      chk("t5_after_clr", stall_cnt, 1);
      hold_req = 3'b000;
      tick();

      // 6: reset asserted during FLUSH on dut3 while cnt=2.
      ex_jump_flag = 1'b1; ex_jump_addr = 32'h500;
      tick();
      ex_jump_flag = 1'b0;
      #1;
      chk("t6_busy_pre", flush_busy3, 1);
      chk("t6_hold_pre", hold_flag3, 4'b0110);
      rst = 1'b0;
      #1;
      chk("t6_hold", hold_flag3, 0);
      chk("t6_busy", flush_busy3, 0);
      chk("t6_jump", pc_jump_flag3, 0);
      chk("t6_addr", pc_jump_addr3, 0);
      chk("t6_scnt", stall_cnt3, 0);
      chk("t6_fcnt", flush_cnt3, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("t6_post_jump", pc_jump_flag3, 0);
      chk("t6_post_hold", hold_flag3, 0);
      chk("t6_post_busy", flush_busy3, 0);
      tick();
      chk("t6_post_fcnt", flush_cnt3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
